// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl_if
// Brief    : Frame-load handshake and display-drive bundle for the scanner.
// Revision : 1.0
// ============================================================================
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    load_valid;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    load_ready;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              num_out;
    logic [NUM_DIGITS-1:0]   anode;
    logic [c_idx_w-1:0]      scan_idx;
    logic                    frame_done;

    modport master (
        output load_valid,
        output load_data,
        output digit_en,
        input  load_ready,
        input  num_out,
        input  anode,
        input  scan_idx,
        input  frame_done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  digit_en,
        output load_ready,
        output num_out,
        output anode,
        output scan_idx,
        output frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Brief    : Time-multiplexed common-anode 7-segment scanner with a shared
//            decoder and tear-free (frame-boundary) display update.
// Revision : 1.0
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_CYCLES  = 2,
    parameter bit ANODE_ACT_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_ctrl_if.slave bus
);

    localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_cnt_max = (BLANK_CYCLES > REFRESH_DIV) ? BLANK_CYCLES : REFRESH_DIV;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_data_w  = 4 * NUM_DIGITS;

    localparam logic [c_cnt_w-1:0]    c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]    c_show_last  = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [3:0]            c_code_blank = 4'hF;
    localparam logic [NUM_DIGITS-1:0] c_anode_off  = {NUM_DIGITS{ANODE_ACT_LOW}};

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    // Scan sequencer state
    logic [0:0]            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_idx;

    // Frame storage and load handshake
    logic [c_data_w-1:0]   r_disp;
    logic [c_data_w-1:0]   r_shadow;
    logic                  r_pending;
    logic                  r_ready;

    // Registered display drive
    logic [3:0]            r_num;
    logic [NUM_DIGITS-1:0] r_anode;
    logic                  r_frame_done;

    logic [0:0]            w_state_nxt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic [c_idx_w-1:0]    w_idx_nxt;
    logic                  w_boundary;
    logic                  w_take;
    logic                  w_commit;
    logic                  w_pending_nxt;
    logic [c_data_w-1:0]   w_disp_nxt;
    logic [3:0]            w_code;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  w_lit;
    logic [3:0]            w_num_nxt;
    logic [NUM_DIGITS-1:0] w_anode_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_boundary  = 1'b0;
        case (r_state)
            c_st_blank: begin
                if (r_cnt == c_blank_last) begin
                    w_state_nxt = c_st_show;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_show: begin
                if (r_cnt == c_show_last) begin
                    w_state_nxt = c_st_blank;
                    w_cnt_nxt   = '0;
                    if (r_idx == c_idx_last) begin
                        w_idx_nxt  = '0;
                        w_boundary = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_blank;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // A transfer needs ready, ready implies no pending frame, so a transfer
    // and a commit can never land on the same edge.
    assign w_take        = bus.load_valid & r_ready;
    assign w_commit      = w_boundary & r_pending;
    assign w_disp_nxt    = w_commit ? r_shadow : r_disp;
    assign w_pending_nxt = w_take | (r_pending & ~w_commit);

    // Outputs are computed from the next state so they line up with it.
    always_comb begin
        w_code   = c_code_blank;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == c_idx_w'(i)) begin
                w_code      = w_disp_nxt[4*i +: 4];
                w_onehot[i] = bus.digit_en[i];
            end
        end
    end

    assign w_lit       = (w_state_nxt == c_st_show) && (|w_onehot);
    assign w_num_nxt   = w_lit ? w_code : c_code_blank;
    assign w_anode_nxt = (w_lit ? w_onehot : '0) ^ c_anode_off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_blank;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_num        <= c_code_blank;
            r_anode      <= c_anode_off;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_num        <= w_num_nxt;
            r_anode      <= w_anode_nxt;
            r_frame_done <= w_boundary;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp    <= {NUM_DIGITS{c_code_blank}};
            r_shadow  <= {NUM_DIGITS{c_code_blank}};
            r_pending <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            if (w_take) begin
                r_shadow <= bus.load_data;
            end
            r_disp    <= w_disp_nxt;
            r_pending <= w_pending_nxt;
            r_ready   <= ~w_pending_nxt;
        end
    end

    assign bus.load_ready = r_ready;
    assign bus.num_out    = r_num;
    assign bus.anode      = r_anode;
    assign bus.scan_idx   = r_idx;
    assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Brief    : Bench for seven_seg_scan_ctrl (4 digits, 3-cycle show, 1 blank).
// Revision : 1.0
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int NUM_DIGITS   = 4;
    localparam int REFRESH_DIV  = 3;
    localparam int BLANK_CYCLES = 1;
    localparam int SLOT         = BLANK_CYCLES + REFRESH_DIV;
    localparam int FRAME        = NUM_DIGITS * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .ANODE_ACT_LOW(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: k counts rising edges since reset release.
    int         k;
    logic [3:0] m_disp   [NUM_DIGITS];
    logic [3:0] m_shadow [NUM_DIGITS];
    bit         m_pending;
    logic [3:0] exp_num;
    logic [3:0] exp_anode;
    logic [1:0] exp_idx;
    logic       exp_fd;
    logic       exp_ready;

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            m_disp[i]   = 4'hF;
            m_shadow[i] = 4'hF;
        end
        m_pending = 1'b0;
        exp_anode = 4'hF;
        exp_num   = 4'hF;
        exp_idx   = 2'd0;
        exp_fd    = 1'b0;
        exp_ready = 1'b1;
    endtask

    // Predicts the outputs after the coming edge, then lets that edge happen.
    task automatic clk_step();
        bit take;
        bit boundary;
        bit lit;
        int phase;
        int dig;
        k++;
        take     = bus.load_valid && !m_pending;
        boundary = (k % FRAME) == 0;
        if (boundary && m_pending) begin
            for (int i = 0; i < NUM_DIGITS; i++) m_disp[i] = m_shadow[i];
            m_pending = 1'b0;
        end
        if (take) begin
            for (int i = 0; i < NUM_DIGITS; i++) m_shadow[i] = bus.load_data[4*i +: 4];
            m_pending = 1'b1;
        end
        phase     = k % FRAME;
        dig       = phase / SLOT;
        lit       = ((phase % SLOT) >= BLANK_CYCLES) && bus.digit_en[dig];
        exp_idx   = 2'(dig);
        exp_anode = lit ? ~(4'b0001 << dig) : 4'hF;
        exp_num   = lit ? m_disp[dig] : 4'hF;
        exp_fd    = boundary;
        exp_ready = !m_pending;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.digit_en   = '1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.anode !== 4'b1111) begin fails++; $display("FAIL reset_anode got=%b exp=%b", bus.anode, 4'b1111); end
        tests++; if (bus.num_out !== 4'hF) begin fails++; $display("FAIL reset_num got=%h exp=%h", bus.num_out, 4'hF); end
        tests++; if (bus.load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.load_ready); end
        tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got=%b exp=0", bus.frame_done); end
        tests++; if (bus.scan_idx !== 2'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", bus.scan_idx); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_scan_random(input int n);
        for (int c = 0; c < n; c++) begin
            bus.digit_en   = 4'($urandom);
            bus.load_valid = ($urandom_range(0, 7) == 0);
            bus.load_data  = 16'($urandom);
            clk_step();
            tests++; if (bus.anode !== exp_anode) begin fails++; $display("FAIL rnd_anode k=%0d got=%b exp=%b", k, bus.anode, exp_anode); end
            tests++; if (bus.num_out !== exp_num) begin fails++; $display("FAIL rnd_num k=%0d got=%h exp=%h", k, bus.num_out, exp_num); end
            tests++; if (bus.scan_idx !== exp_idx) begin fails++; $display("FAIL rnd_idx k=%0d got=%0d exp=%0d", k, bus.scan_idx, exp_idx); end
            tests++; if (bus.frame_done !== exp_fd) begin fails++; $display("FAIL rnd_fd k=%0d got=%b exp=%b", k, bus.frame_done, exp_fd); end
            tests++; if (bus.load_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, bus.load_ready, exp_ready); end
        end
        bus.load_valid = 1'b0;
    endtask

    // Offers one frame at a chosen frame phase, then watches n cycles.
    task automatic test_load(input logic [15:0] data, input int at_phase,
                             input logic [3:0] en, input int n);
        bus.digit_en   = en;
        bus.load_valid = 1'b0;
        for (int c = 0; c < FRAME && (k % FRAME) != at_phase; c++) clk_step();
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        clk_step();
        bus.load_valid = 1'b0;
        for (int c = 0; c < n; c++) begin
            bus.load_data = 16'($urandom);
            clk_step();
            tests++; if (bus.anode !== exp_anode) begin fails++; $display("FAIL load_anode d=%h k=%0d got=%b exp=%b", data, k, bus.anode, exp_anode); end
            tests++; if (bus.num_out !== exp_num) begin fails++; $display("FAIL load_num d=%h k=%0d got=%h exp=%h", data, k, bus.num_out, exp_num); end
            tests++; if (bus.scan_idx !== exp_idx) begin fails++; $display("FAIL load_idx d=%h k=%0d got=%0d exp=%0d", data, k, bus.scan_idx, exp_idx); end
            tests++; if (bus.frame_done !== exp_fd) begin fails++; $display("FAIL load_fd d=%h k=%0d got=%b exp=%b", data, k, bus.frame_done, exp_fd); end
            tests++; if (bus.load_ready !== exp_ready) begin fails++; $display("FAIL load_ready d=%h k=%0d got=%b exp=%b", data, k, bus.load_ready, exp_ready); end
        end
    endtask

    task automatic test_digit_en_mask();
        bus.digit_en   = 4'b1011;
        bus.load_valid = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            clk_step();
            tests++; if (bus.anode !== exp_anode) begin fails++; $display("FAIL mask_anode k=%0d got=%b exp=%b", k, bus.anode, exp_anode); end
            tests++; if (bus.num_out !== exp_num) begin fails++; $display("FAIL mask_num k=%0d got=%h exp=%h", k, bus.num_out, exp_num); end
            if (exp_idx == 2'd2) begin
                tests++; if (bus.anode !== 4'b1111) begin fails++; $display("FAIL mask_slot2_dark k=%0d got=%b exp=1111", k, bus.anode); end
            end
        end
        bus.digit_en = 4'b1111;
    endtask

    task automatic test_back_to_back();
        int took_at;
        took_at        = -1;
        bus.digit_en   = 4'b1111;
        bus.load_valid = 1'b0;
        for (int c = 0; c < FRAME && (k % FRAME) != 5; c++) clk_step();
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h1234;
        clk_step();
        bus.load_data  = 16'h5678;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (took_at < 0 && bus.load_ready === 1'b1) took_at = k + 1;
            if (took_at >= 0 && k >= took_at) bus.load_valid = 1'b0;
            clk_step();
            tests++; if (bus.anode !== exp_anode) begin fails++; $display("FAIL b2b_anode k=%0d got=%b exp=%b", k, bus.anode, exp_anode); end
            tests++; if (bus.num_out !== exp_num) begin fails++; $display("FAIL b2b_num k=%0d got=%h exp=%h", k, bus.num_out, exp_num); end
            tests++; if (bus.load_ready !== exp_ready) begin fails++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, bus.load_ready, exp_ready); end
            tests++; if (bus.frame_done !== exp_fd) begin fails++; $display("FAIL b2b_fd k=%0d got=%b exp=%b", k, bus.frame_done, exp_fd); end
        end
        // Second frame must go in on the edge right after the commit edge.
        tests++; if ((took_at % FRAME) != 1) begin fails++; $display("FAIL b2b_take_phase got=%0d exp=1", took_at % FRAME); end
        bus.load_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.digit_en   = 4'b1111;
        bus.load_valid = 1'b0;
        for (int c = 0; c < FRAME && (k % FRAME) != 1; c++) clk_step();
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h9876;
        clk_step();
        bus.load_valid = 1'b0;
        for (int c = 0; c < FRAME && (k % FRAME) != 2 * SLOT + 2; c++) clk_step();
        tests++; if (bus.anode !== 4'b1011) begin fails++; $display("FAIL rstmid_pre_anode got=%b exp=1011", bus.anode); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (bus.anode !== 4'b1111) begin fails++; $display("FAIL rstmid_anode got=%b exp=1111", bus.anode); end
        tests++; if (bus.num_out !== 4'hF) begin fails++; $display("FAIL rstmid_num got=%h exp=f", bus.num_out); end
        tests++; if (bus.load_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%b exp=1", bus.load_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            clk_step();
            tests++; if (bus.anode !== exp_anode) begin fails++; $display("FAIL rstmid_post_anode k=%0d got=%b exp=%b", k, bus.anode, exp_anode); end
            tests++; if (bus.num_out !== 4'hF) begin fails++; $display("FAIL rstmid_post_num k=%0d got=%h exp=f", k, bus.num_out); end
            tests++; if (bus.scan_idx !== exp_idx) begin fails++; $display("FAIL rstmid_post_idx k=%0d got=%0d exp=%0d", k, bus.scan_idx, exp_idx); end
            tests++; if (bus.frame_done !== exp_fd) begin fails++; $display("FAIL rstmid_post_fd k=%0d got=%b exp=%b", k, bus.frame_done, exp_fd); end
        end
    endtask

    initial begin
        test_reset();
        test_scan_random(2 * FRAME);
        test_load(16'h1234, 6, 4'b1111, 3 * FRAME);
        test_digit_en_mask();
        test_back_to_back();
        test_load(16'hFA90, 9, 4'b1111, 3 * FRAME);
        test_reset_mid();
        test_scan_random(6 * FRAME);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
